// File: rtl/tone_scheduler.sv
`default_nettype none
// ============================================================================
// tone_scheduler: queues keypad presses and plays each one as a timed PWM tone
// Revision: 1.0
// ============================================================================
module tone_scheduler #(
    parameter int BASE_N      = 1000,
    parameter int STEP_N      = 100,
    parameter int TONE_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 5000000,
    parameter int CNT_W       = 25,
    parameter int DEPTH       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_pos,
    input  logic        key_opr,
    output logic [11:0] n_freq,
    output logic        tone_en,
    output logic        reg_we,
    output logic [3:0]  reg_addr,
    output logic [2:0]  reg_data,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int                ADDR_W    = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   FULL_CNT  = DEPTH[ADDR_W:0];
    localparam logic [CNT_W-1:0]  TONE_LAST = CNT_W'(TONE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                opr_q;
    logic [3:0]          mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]     count_q;
    logic                overflow_q;
    logic [11:0]         n_freq_q, n_freq_d;
    logic [3:0]          reg_addr_q, reg_addr_d;
    logic [2:0]          reg_data_q;
    logic                tone_en_q, reg_we_q, busy_q;

    logic                w_push, w_pop, w_full, w_empty, w_accept;
    logic [3:0]          w_head;
    logic [11:0]         w_freq;

    assign w_push   = key_opr & ~opr_q;
    assign w_empty  = (count_q == '0);
    assign w_full   = (count_q == FULL_CNT);
    assign w_pop    = (state_q == S_LOAD);
    // A full FIFO still accepts a press when the head leaves in the same cycle
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_head   = mem_q[rd_ptr_q];
    assign w_freq   = 12'(BASE_N) + 12'(STEP_N) * {8'd0, w_head};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_freq_d   = n_freq_q;
        reg_addr_d = reg_addr_q;
        case (state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d    = S_PLAY;
                cnt_d      = TONE_LAST;
                reg_addr_d = w_head;
                n_freq_d   = w_freq;
            end
            S_PLAY: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LAST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = (!w_empty || w_push) ? S_LOAD : S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            opr_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            n_freq_q   <= 12'(BASE_N);
            reg_addr_q <= 4'd0;
            reg_data_q <= 3'd1;
            tone_en_q  <= 1'b0;
            reg_we_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opr_q      <= key_opr;
            n_freq_q   <= n_freq_d;
            reg_addr_q <= reg_addr_d;
            tone_en_q  <= (state_d == S_PLAY);
            reg_we_q   <= w_pop;
            busy_q     <= (state_d != S_IDLE);
            // Color code advances after each write and never takes the value 0
            if (reg_we_q) begin
                reg_data_q <= (reg_data_q == 3'd7) ? 3'd1 : reg_data_q + 3'd1;
            end
            if (w_accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (w_accept && !w_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!w_accept && w_pop) begin
                count_q <= count_q - 1'b1;
            end
            if (w_push && w_full && !w_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            mem_q[wr_ptr_q] <= key_pos;
        end
    end

    assign n_freq    = n_freq_q;
    assign tone_en   = tone_en_q;
    assign reg_we    = reg_we_q;
    assign reg_addr  = reg_addr_q;
    assign reg_data  = reg_data_q;
    assign busy      = busy_q;
    assign fifo_full = w_full;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_tone_scheduler.sv
`default_nettype none
// ============================================================================
// tb_tone_scheduler: directed self-checking bench for tone_scheduler
// Revision: 1.0
// ============================================================================
module tb_tone_scheduler;

    localparam int TONE  = 8;
    localparam int GAP   = 4;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  key_pos;
    logic        key_opr;
    logic [11:0] n_freq;
    logic        tone_en;
    logic        reg_we;
    logic [3:0]  reg_addr;
    logic [2:0]  reg_data;
    logic        busy;
    logic        fifo_full;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    // Observation log filled on the falling edge
    int          cyc = 0;
    int          log_n = 0;
    logic [3:0]  log_addr [64];
    logic [2:0]  log_data [64];
    logic [11:0] log_freq [64];
    int          log_cyc  [64];
    int          tone_n = 0;
    int          tone_len [64];
    int          run = 0;
    int          tone_hi = 0;

    tone_scheduler #(
        .BASE_N      (1000),
        .STEP_N      (100),
        .TONE_CYCLES (TONE),
        .GAP_CYCLES  (GAP),
        .CNT_W       (4),
        .DEPTH       (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_pos   (key_pos),
        .key_opr   (key_opr),
        .n_freq    (n_freq),
        .tone_en   (tone_en),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_data  (reg_data),
        .busy      (busy),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            run = 0;
        end else begin
            if (reg_we && log_n < 64) begin
                log_addr[log_n] = reg_addr;
                log_data[log_n] = reg_data;
                log_freq[log_n] = n_freq;
                log_cyc[log_n]  = cyc;
                log_n = log_n + 1;
            end
            if (tone_en) begin
                run     = run + 1;
                tone_hi = tone_hi + 1;
            end else if (run > 0) begin
                if (tone_n < 64) tone_len[tone_n] = run;
                tone_n = tone_n + 1;
                run = 0;
            end
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        key_opr = 1'b0;
        key_pos = 4'd0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    // One-cycle press followed by one idle cycle; the push lands on the first edge
    task automatic press(input logic [3:0] pos);
        key_pos = pos;
        key_opr = 1'b1;
        step(1);
        key_opr = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (n_freq !== 12'd1000) begin n_err++; $display("FAIL reset_n_freq: got %0d want 1000", n_freq); end
        n_cmp++; if (tone_en !== 1'b0) begin n_err++; $display("FAIL reset_tone_en: got %b want 0", tone_en); end
        n_cmp++; if (reg_we !== 1'b0) begin n_err++; $display("FAIL reset_reg_we: got %b want 0", reg_we); end
        n_cmp++; if (reg_addr !== 4'd0) begin n_err++; $display("FAIL reset_reg_addr: got %0d want 0", reg_addr); end
        n_cmp++; if (reg_data !== 3'd1) begin n_err++; $display("FAIL reset_reg_data: got %0d want 1", reg_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL reset_fifo_full: got %b want 0", fifo_full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_single_press();
        int  b, tb0;
        logic exp_tone, exp_busy, exp_we;
        do_reset();
        b   = log_n;
        tb0 = tone_n;
        key_pos = 4'd5;
        key_opr = 1'b1;
        // i counts edges from the push edge (i = 1)
        for (int i = 1; i <= 20; i++) begin
            step(1);
            exp_tone = (i >= 3 && i <= 10);
            exp_busy = (i >= 2 && i <= 14);
            exp_we   = (i == 3);
            n_cmp++; if (tone_en !== exp_tone) begin n_err++; $display("FAIL single_tone_en edge%0d: got %b want %b", i, tone_en, exp_tone); end
            n_cmp++; if (busy !== exp_busy) begin n_err++; $display("FAIL single_busy edge%0d: got %b want %b", i, busy, exp_busy); end
            n_cmp++; if (reg_we !== exp_we) begin n_err++; $display("FAIL single_reg_we edge%0d: got %b want %b", i, reg_we, exp_we); end
        end
        key_opr = 1'b0;
        step(3);
        n_cmp++; if (log_n - b !== 1) begin n_err++; $display("FAIL single_we_count: got %0d want 1", log_n - b); end
        n_cmp++; if (log_addr[b] !== 4'd5) begin n_err++; $display("FAIL single_addr: got %0d want 5", log_addr[b]); end
        n_cmp++; if (log_data[b] !== 3'd1) begin n_err++; $display("FAIL single_data: got %0d want 1", log_data[b]); end
        n_cmp++; if (log_freq[b] !== 12'd1500) begin n_err++; $display("FAIL single_n_freq: got %0d want 1500", log_freq[b]); end
        n_cmp++; if (tone_n - tb0 !== 1 || tone_len[tb0] !== TONE) begin n_err++; $display("FAIL single_tone_len: got %0d tones len %0d want 1 len %0d", tone_n - tb0, tone_len[tb0], TONE); end
        n_cmp++; if (reg_data !== 3'd2) begin n_err++; $display("FAIL single_reg_data_after: got %0d want 2", reg_data); end
    endtask

    task automatic test_back_to_back();
        int b, tb0;
        logic [11:0] exp_f [3];
        logic [3:0]  exp_a [3];
        exp_f[0] = 12'd1000; exp_f[1] = 12'd2500; exp_f[2] = 12'd1300;
        exp_a[0] = 4'd0;     exp_a[1] = 4'd15;    exp_a[2] = 4'd3;
        do_reset();
        b   = log_n;
        tb0 = tone_n;
        press(4'd0);
        press(4'd15);
        press(4'd3);
        step(60);
        n_cmp++; if (log_n - b !== 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", log_n - b); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (log_freq[b+k] !== exp_f[k]) begin n_err++; $display("FAIL b2b_n_freq[%0d]: got %0d want %0d", k, log_freq[b+k], exp_f[k]); end
            n_cmp++; if (log_addr[b+k] !== exp_a[k]) begin n_err++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", k, log_addr[b+k], exp_a[k]); end
            n_cmp++; if (log_data[b+k] !== 3'(k + 1)) begin n_err++; $display("FAIL b2b_data[%0d]: got %0d want %0d", k, log_data[b+k], k + 1); end
            n_cmp++; if (tone_len[tb0+k] !== TONE) begin n_err++; $display("FAIL b2b_tone_len[%0d]: got %0d want %0d", k, tone_len[tb0+k], TONE); end
        end
        for (int k = 1; k < 3; k++) begin
            n_cmp++; if (log_cyc[b+k] - log_cyc[b+k-1] !== TONE + GAP + 1) begin n_err++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", k, log_cyc[b+k] - log_cyc[b+k-1], TONE + GAP + 1); end
        end
    endtask

    task automatic test_overflow();
        int b;
        do_reset();
        b = log_n;
        press(4'd1);
        step(1);
        n_cmp++; if (tone_en !== 1'b1) begin n_err++; $display("FAIL ovf_first_tone: got %b want 1", tone_en); end
        press(4'd2);
        press(4'd3);
        press(4'd4);
        n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL ovf_not_full_3: got %b want 0", fifo_full); end
        press(4'd5);
        n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b want 1", fifo_full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", overflow); end
        press(4'd6);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow); end
        step(90);
        n_cmp++; if (log_n - b !== 5) begin n_err++; $display("FAIL ovf_tone_count: got %0d want 5", log_n - b); end
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (log_addr[b+k] !== 4'(k + 1)) begin n_err++; $display("FAIL ovf_addr[%0d]: got %0d want %0d", k, log_addr[b+k], k + 1); end
        end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        n_cmp++; if (fifo_full !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got full=%b busy=%b want 0 0", fifo_full, busy); end
    endtask

    task automatic test_collision();
        int b;
        do_reset();
        b = log_n;
        press(4'd0);
        step(1);
        press(4'd1);
        press(4'd2);
        press(4'd3);
        press(4'd4);
        n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL coll_full: got %b want 1", fifo_full); end
        step(4);
        // Second LOAD cycle: gap just ended, no tone yet
        n_cmp++; if (busy !== 1'b1 || tone_en !== 1'b0) begin n_err++; $display("FAIL coll_in_load: got busy=%b tone=%b want 1 0", busy, tone_en); end
        key_pos = 4'd5;
        key_opr = 1'b1;
        step(1);
        key_opr = 1'b0;
        n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL coll_still_full: got %b want 1", fifo_full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL coll_overflow: got %b want 0", overflow); end
        step(100);
        n_cmp++; if (log_n - b - 1 !== DEPTH + 1) begin n_err++; $display("FAIL coll_tones_from_load: got %0d want %0d", log_n - b - 1, DEPTH + 1); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if (log_addr[b+k] !== 4'(k)) begin n_err++; $display("FAIL coll_addr[%0d]: got %0d want %0d", k, log_addr[b+k], k); end
        end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL coll_overflow_end: got %b want 0", overflow); end
    endtask

    task automatic test_async_reset();
        int b, th;
        do_reset();
        press(4'd2);
        press(4'd1);
        press(4'd3);
        n_cmp++; if (tone_en !== 1'b1 || n_freq !== 12'd1200) begin n_err++; $display("FAIL areset_pre: got tone=%b n_freq=%0d want 1 1200", tone_en, n_freq); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (tone_en !== 1'b0) begin n_err++; $display("FAIL areset_tone_en: got %b want 0", tone_en); end
        n_cmp++; if (n_freq !== 12'd1000) begin n_err++; $display("FAIL areset_n_freq: got %0d want 1000", n_freq); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL areset_busy: got %b want 0", busy); end
        step(2);
        rst = 1'b0;
        b  = log_n;
        th = tone_hi;
        step(40);
        n_cmp++; if (tone_hi - th !== 0 || log_n - b !== 0) begin n_err++; $display("FAIL areset_no_tone: got %0d tone cycles %0d writes want 0 0", tone_hi - th, log_n - b); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL areset_idle: got %b want 0", busy); end
        press(4'd7);
        step(4);
        n_cmp++; if (log_n - b !== 1 || log_addr[b] !== 4'd7) begin n_err++; $display("FAIL areset_new_press: got %0d writes addr %0d want 1 addr 7", log_n - b, log_addr[b]); end
    endtask

    task automatic test_reg_data_wrap();
        int b;
        logic [2:0] exp_d [8];
        exp_d[0] = 3'd1; exp_d[1] = 3'd2; exp_d[2] = 3'd3; exp_d[3] = 3'd4;
        exp_d[4] = 3'd5; exp_d[5] = 3'd6; exp_d[6] = 3'd7; exp_d[7] = 3'd1;
        do_reset();
        b = log_n;
        for (int k = 0; k < 8; k++) begin
            press(4'(k + 8));
            step(14);
        end
        n_cmp++; if (log_n - b !== 8) begin n_err++; $display("FAIL wrap_count: got %0d want 8", log_n - b); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (log_data[b+k] !== exp_d[k]) begin n_err++; $display("FAIL wrap_data[%0d]: got %0d want %0d", k, log_data[b+k], exp_d[k]); end
        end
        n_cmp++; if (log_freq[b+7] !== 12'd2500) begin n_err++; $display("FAIL wrap_n_freq_last: got %0d want 2500", log_freq[b+7]); end
    endtask

    initial begin
        rst     = 1'b1;
        key_opr = 1'b0;
        key_pos = 4'd0;
        test_reset();
        test_single_press();
        test_back_to_back();
        test_overflow();
        test_collision();
        test_async_reset();
        test_reg_data_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
